sbox_sched: RTL



---
 rtl/sbox_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sbox_sched.sv
// sbox_sched: arbitrates the four Blowfish S-box banks between round lookups and buffered key-expansion writes.
// Define SBOX_SCHED_FWD_EN to forward pending FIFO rows to hazarding reads instead of stalling them.
module sbox_sched #(
   parameter int ROW_W      = 7,
   parameter int WBUF_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_req,
   input  logic [31:0]          rd_idx,
   output logic                 rd_gnt,
   output logic                 rd_valid,
   output logic [127:0]         rd_data,
   input  logic                 wr_req,
   input  logic [1:0]           wr_bank,
   input  logic [ROW_W-1:0]     wr_row,
   input  logic [63:0]          wr_data,
   output logic                 wr_ack,
   output logic                 wr_full,
   input  logic                 flush,
   output logic                 flush_done,
   output logic [3:0]           mem_en,
   output logic [3:0]           mem_we,
   output logic [4*ROW_W-1:0]   mem_row,
   output logic [63:0]          mem_wdata,
   input  logic [255:0]         mem_rdata
);
   localparam int AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
   localparam int CW = AW + 1;
   typedef enum logic {RUN, DRAIN} state_t;
   state_t state_q, state_d;
   logic [1:0]       bank_q [WBUF_DEPTH];
   logic [ROW_W-1:0] row_q  [WBUF_DEPTH];
   logic [63:0]      data_q [WBUF_DEPTH];
   logic [AW-1:0]    rptr_q, wptr_q;
   logic [CW-1:0]    cnt_q;
   logic             rv_q;
   logic [3:0]       sel_q, hit_d;
   logic [127:0]     hold_q, rdw;
   logic [63:0]      w;
   logic             ne, full, blk, force_wr, do_rd, do_wr, push;
`ifdef SBOX_SCHED_FWD_EN
   logic [3:0]       hit_q;
   logic [63:0]      fwd_d [4];
   logic [63:0]      fwd_q [4];
`endif

   // later (younger) entries override earlier matches
   always_comb begin
      hit_d = '0;
`ifdef SBOX_SCHED_FWD_EN
      for (int k = 0; k < 4; k++) fwd_d[k] = '0;
`endif
      for (int i = 0; i < WBUF_DEPTH; i++)
         for (int k = 0; k < 4; k++)
            if (CW'(i) < cnt_q && bank_q[rptr_q + AW'(i)] == 2'(k) &&
                row_q[rptr_q + AW'(i)] == rd_idx[8*k+1 +: ROW_W]) begin
               hit_d[k] = 1'b1;
`ifdef SBOX_SCHED_FWD_EN
               fwd_d[k] = data_q[rptr_q + AW'(i)];
`endif
            end
   end

   assign ne       = cnt_q != '0;
   assign full     = cnt_q == CW'(WBUF_DEPTH);
`ifdef SBOX_SCHED_FWD_EN
   assign blk      = 1'b0;
`else
   assign blk      = rd_req && |hit_d;
`endif
   assign force_wr = ne && (full || state_q == DRAIN || blk);
   assign do_rd    = !force_wr && rd_req && state_q == RUN;
   assign do_wr    = ne && !do_rd;
   assign push     = wr_req && !full;
   assign state_d  = (state_q == RUN) ? (flush ? DRAIN : RUN) : (ne ? DRAIN : RUN);

   assign rd_gnt     = do_rd && !rst;
   assign wr_ack     = push && !rst;
   assign wr_full    = full;
   assign flush_done = !rst && state_q == DRAIN && !ne;
   assign rd_valid   = rv_q;
   assign rd_data    = rv_q ? rdw : hold_q;

   always_comb begin
      mem_en    = '0;
      mem_we    = '0;
      mem_row   = '0;
      mem_wdata = '0;
      if (!rst && do_rd) begin
         mem_en = 4'hF;
         for (int k = 0; k < 4; k++) mem_row[k*ROW_W +: ROW_W] = rd_idx[8*k+1 +: ROW_W];
      end else if (!rst && do_wr) begin
         mem_en[bank_q[rptr_q]]                  = 1'b1;
         mem_we[bank_q[rptr_q]]                  = 1'b1;
         mem_row[bank_q[rptr_q]*ROW_W +: ROW_W] = row_q[rptr_q];
         mem_wdata                               = data_q[rptr_q];
      end
   end

   always_comb begin
      rdw = '0;
      w   = '0;
      for (int k = 0; k < 4; k++) begin
`ifdef SBOX_SCHED_FWD_EN
         w = hit_q[k] ? fwd_q[k] : mem_rdata[64*k +: 64];
`else
         w = mem_rdata[64*k +: 64];
`endif
         rdw[32*k +: 32] = sel_q[k] ? w[63:32] : w[31:0];
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= RUN;
         rptr_q  <= '0;
         wptr_q  <= '0;
         cnt_q   <= '0;
         rv_q    <= 1'b0;
         sel_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         rv_q    <= do_rd;
         cnt_q   <= cnt_q + CW'(push) - CW'(do_wr);
         if (push) wptr_q <= wptr_q + AW'(1);
         if (do_wr) rptr_q <= rptr_q + AW'(1);
         if (do_rd) sel_q <= {rd_idx[24], rd_idx[16], rd_idx[8], rd_idx[0]};
         if (rv_q) hold_q <= rdw;
      end

   // payload storage needs no reset: occupancy is tracked by cnt_q and rv_q
   always_ff @(posedge clk) begin
      if (push) begin
         bank_q[wptr_q] <= wr_bank;
         row_q[wptr_q]  <= wr_row;
         data_q[wptr_q] <= wr_data;
      end
`ifdef SBOX_SCHED_FWD_EN
      if (do_rd) begin
         hit_q <= hit_d;
         fwd_q <= fwd_d;
      end
`endif
   end
endmodule
